compressed_decoder: RTL and testbench

// - Combinational RV32C expander that sits between the instruction fetch/trace path and the 32-bit decoder.
// - Converts any 16-bit compressed instruction into its equivalent 32-bit RV32I/F encoding.
// - Passes 32-bit instructions through unchanged and flags compressed encodings that are illegal or unsupported.

---
 rtl/compressed_decoder_if.sv | 29 ++
 rtl/compressed_decoder.sv | 196 +++++++++++++++++++
 tb/tb_compressed_decoder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/compressed_decoder_if.sv
// rtl/compressed_decoder_if.sv - instruction in / expanded instruction out bundle for compressed_decoder
//
// Signals:
//   instr_i          raw fetched instruction (compressed form in [15:0])
//   instr_o          expanded 32-bit instruction
//   is_compressed_o  instr_i[1:0] != 2'b11
//   illegal_instr_o  illegal or unsupported compressed encoding
// Modports: master drives instr_i (fetch side), slave is the decoder.

interface compressed_decoder_if;
  logic [31:0] instr_i;
  logic [31:0] instr_o;
  logic        is_compressed_o;
  logic        illegal_instr_o;

  modport master (
    output instr_i,
    input  instr_o,
    input  is_compressed_o,
    input  illegal_instr_o
  );

  modport slave (
    input  instr_i,
    output instr_o,
    output is_compressed_o,
    output illegal_instr_o
  );
endinterface

// File: rtl/compressed_decoder.sv
// rtl/compressed_decoder.sv - combinational RV32C to RV32I/F instruction expander
//
// Parameters:
//   FPU     1: expand C.FLW/C.FSW/C.FLWSP/C.FSWSP, 0: treat them as illegal
// Ports:
//   clk_i   clock (interface uniformity only, does not gate outputs)
//   rst_ni  asynchronous active-low reset (interface uniformity only)
//   bus     compressed_decoder_if.slave: instr_i in, instr_o/is_compressed_o/illegal_instr_o out
// Zero latency, no state: outputs follow instr_i at all times, including in reset.

module compressed_decoder #(
  parameter bit FPU = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  compressed_decoder_if.slave  bus
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  // Clock and reset are carried for a uniform block interface only.
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_ni;

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs2p;
  logic [11:0] imm6;
  logic [19:0] jal_imm;     // instruction bits [31:12] of the JAL encoding
  logic [6:0]  br_hi;       // instruction bits [31:25] of the branch encoding
  logic [4:0]  br_lo;       // instruction bits [11:7] of the branch encoding
  logic [11:0] ld_off;      // C.LW/C.FLW offset, zero-extended
  logic [11:0] lwsp_off;    // C.LWSP/C.FLWSP offset, zero-extended
  logic [11:0] sw_off;      // C.SW/C.FSW offset, zero-extended
  logic [11:0] swsp_off;    // C.SWSP/C.FSWSP offset, zero-extended
  logic [9:0]  addi4spn_imm;
  logic [11:0] addi16sp_imm;

  logic [31:0] instr;
  logic        illegal;

  assign c    = bus.instr_i[15:0];
  assign rd   = c[11:7];
  assign rs2  = c[6:2];
  assign rdp  = {2'b01, c[9:7]};
  assign rs2p = {2'b01, c[4:2]};
  assign imm6 = {{6{c[12]}}, c[12], c[6:2]};

  // JAL fields: {imm[20], imm[10:1], imm[11], imm[19:12]} with imm sign-extended from c[12]
  assign jal_imm = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}}};

  // Branch fields: {imm[12], imm[10:5]} and {imm[4:1], imm[11]}
  assign br_hi = {c[12], c[12], c[12], c[12], c[6:5], c[2]};
  assign br_lo = {c[11:10], c[4:3], c[12]};

  assign ld_off       = {5'b0, c[5], c[12:10], c[6], 2'b00};
  assign sw_off       = ld_off;
  assign lwsp_off     = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
  assign swsp_off     = {4'b0, c[8:7], c[12:9], 2'b00};
  assign addi4spn_imm = {c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign addi16sp_imm = {{3{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0000};

  always_comb begin
    instr   = bus.instr_i;
    illegal = 1'b0;

    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin
            instr = {2'b00, addi4spn_imm, 5'd2, 3'b000, rs2p, OPC_OP_IMM};
            if (addi4spn_imm == 10'd0) illegal = 1'b1;
          end
          3'b010: instr = {ld_off, rdp, 3'b010, rs2p, OPC_LOAD};
          3'b011: begin
            if (FPU) instr = {ld_off, rdp, 3'b010, rs2p, OPC_LOAD_FP};
            else     illegal = 1'b1;
          end
          3'b110: instr = {sw_off[11:5], rs2p, rdp, 3'b010, sw_off[4:0], OPC_STORE};
          3'b111: begin
            if (FPU) instr = {sw_off[11:5], rs2p, rdp, 3'b010, sw_off[4:0], OPC_STORE_FP};
            else     illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end

      2'b01: begin
        case (c[15:13])
          3'b000: instr = {imm6, rd, 3'b000, rd, OPC_OP_IMM};
          3'b001: instr = {jal_imm, 5'd1, OPC_JAL};
          3'b010: instr = {imm6, 5'd0, 3'b000, rd, OPC_OP_IMM};
          3'b011: begin
            if (rd == 5'd2) begin
              instr = {addi16sp_imm, 5'd2, 3'b000, 5'd2, OPC_OP_IMM};
              if ({c[12], c[6:2]} == 6'd0) illegal = 1'b1;
            end else begin
              instr = {{14{c[12]}}, c[12], c[6:2], rd, OPC_LUI};
              if ({c[12], c[6:2]} == 6'd0) illegal = 1'b1;
            end
          end
          3'b100: begin
            case (c[11:10])
              2'b00: begin
                instr = {7'b0000000, c[6:2], rdp, 3'b101, rdp, OPC_OP_IMM};
                if (c[12]) illegal = 1'b1;
              end
              2'b01: begin
                instr = {7'b0100000, c[6:2], rdp, 3'b101, rdp, OPC_OP_IMM};
                if (c[12]) illegal = 1'b1;
              end
              2'b10: instr = {imm6, rdp, 3'b111, rdp, OPC_OP_IMM};
              default: begin
                if (c[12]) begin
                  illegal = 1'b1;
                end else begin
                  case (c[6:5])
                    2'b00:   instr = {7'b0100000, rs2p, rdp, 3'b000, rdp, OPC_OP};
                    2'b01:   instr = {7'b0000000, rs2p, rdp, 3'b100, rdp, OPC_OP};
                    2'b10:   instr = {7'b0000000, rs2p, rdp, 3'b110, rdp, OPC_OP};
                    default: instr = {7'b0000000, rs2p, rdp, 3'b111, rdp, OPC_OP};
                  endcase
                end
              end
            endcase
          end
          3'b101: instr = {jal_imm, 5'd0, OPC_JAL};
          3'b110: instr = {br_hi, 5'd0, rdp, 3'b000, br_lo, OPC_BRANCH};
          default: instr = {br_hi, 5'd0, rdp, 3'b001, br_lo, OPC_BRANCH};
        endcase
      end

      2'b10: begin
        case (c[15:13])
          3'b000: begin
            instr = {7'b0000000, c[6:2], rd, 3'b001, rd, OPC_OP_IMM};
            if (c[12]) illegal = 1'b1;
          end
          3'b010: begin
            instr = {lwsp_off, 5'd2, 3'b010, rd, OPC_LOAD};
            if (rd == 5'd0) illegal = 1'b1;
          end
          3'b011: begin
            if (FPU) instr = {lwsp_off, 5'd2, 3'b010, rd, OPC_LOAD_FP};
            else     illegal = 1'b1;
          end
          3'b100: begin
            if (!c[12]) begin
              if (rs2 == 5'd0) begin
                instr = {12'd0, rd, 3'b000, 5'd0, OPC_JALR};
                if (rd == 5'd0) illegal = 1'b1;
              end else begin
                instr = {7'b0000000, rs2, 5'd0, 3'b000, rd, OPC_OP};
              end
            end else begin
              if (rd == 5'd0 && rs2 == 5'd0) begin
                instr = 32'h00100073;
              end else if (rs2 == 5'd0) begin
                instr = {12'd0, rd, 3'b000, 5'd1, OPC_JALR};
              end else begin
                instr = {7'b0000000, rs2, rd, 3'b000, rd, OPC_OP};
              end
            end
          end
          3'b110: instr = {swsp_off[11:5], rs2, 5'd2, 3'b010, swsp_off[4:0], OPC_STORE};
          3'b111: begin
            if (FPU) instr = {swsp_off[11:5], rs2, 5'd2, 3'b010, swsp_off[4:0], OPC_STORE_FP};
            else     illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end

      default: begin
        instr   = bus.instr_i;
        illegal = 1'b0;
      end
    endcase

    // An illegal encoding is handed on untouched so the trap path sees the raw bits.
    if (illegal) instr = bus.instr_i;
  end

  assign bus.instr_o         = instr;
  assign bus.illegal_instr_o = illegal;
  assign bus.is_compressed_o = (c[1:0] != 2'b11);

endmodule

// File: tb/tb_compressed_decoder.sv
// tb/tb_compressed_decoder.sv - self-checking bench for compressed_decoder (FPU=0 and FPU=1 instances)

module tb_compressed_decoder;

  logic clk_i;
  logic rst_ni;

  compressed_decoder_if b0 ();
  compressed_decoder_if b1 ();

  compressed_decoder #(.FPU(1'b0)) dut0 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(b0));
  compressed_decoder #(.FPU(1'b1)) dut1 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(b1));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] in;
    logic [31:0] o;
    logic        c;
    logic        ill;
    bit          fpu;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Drives both instances and records the expectation for the chosen instance.
  task automatic drive(input bit fpu, input logic [31:0] instr, input logic [31:0] exp_o,
                       input logic exp_c, input logic exp_ill);
    exp_t e;
    @(negedge clk_i);
    b0.instr_i = instr;
    b1.instr_i = instr;
    e.in  = instr;
    e.o   = exp_ill ? instr : exp_o;
    e.c   = exp_c;
    e.ill = exp_ill;
    e.fpu = fpu;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [33:0] got;
    rst_ni = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 32'h00004501, 32'h00000513, 1'b1, 1'b0);
      #1;
      e   = sb.pop_front();
      got = {b0.instr_o, b0.is_compressed_o, b0.illegal_instr_o};
      checks++;
      if (got !== {e.o, e.c, e.ill}) begin
        errors++;
        $display("FAIL reset_%0d in=%h got o=%h c=%b ill=%b exp o=%h c=%b ill=%b",
                 k, e.in, got[33:2], got[1], got[0], e.o, e.c, e.ill);
      end
      rst_ni = 1'b1;
    end
  endtask

  task automatic test_passthrough();
    exp_t        e;
    logic [33:0] got;
    logic [31:0] v;
    for (int k = 0; k < 10; k++) begin
      v = (k == 0) ? 32'h00000013 : $urandom();
      v[1:0] = 2'b11;
      drive(k[0], v, v, 1'b0, 1'b0);
      #1;
      e   = sb.pop_front();
      got = e.fpu ? {b1.instr_o, b1.is_compressed_o, b1.illegal_instr_o}
                  : {b0.instr_o, b0.is_compressed_o, b0.illegal_instr_o};
      checks++;
      if (got !== {e.o, e.c, e.ill}) begin
        errors++;
        $display("FAIL passthrough in=%h got o=%h c=%b ill=%b exp o=%h c=%b ill=%b",
                 e.in, got[33:2], got[1], got[0], e.o, e.c, e.ill);
      end
    end
  endtask

  task automatic test_expand();
    exp_t        e;
    logic [33:0] got;
    logic [15:0] up;
    logic [15:0] ci [31];
    logic [31:0] xo [31];
    logic        xi [31];
    ci = '{16'h4501, 16'h8082, 16'h9002, 16'h0040, 16'h4488, 16'hC488, 16'h10FD, 16'hA009,
           16'h3FFD, 16'h6285, 16'h6141, 16'h8405, 16'h8C05, 16'h8C65, 16'hC009, 16'hFC7D,
           16'h008E, 16'h4092, 16'hC206, 16'h852E, 16'h952E, 16'h9282, 16'h4001,
           16'h0000, 16'h6281, 16'h6101, 16'h9405, 16'h9C05, 16'h4002, 16'h8002, 16'hA002};
    xo = '{32'h00000513, 32'h00008067, 32'h00100073, 32'h00410413, 32'h0084A503, 32'h00A4A423,
           32'hFFF08093, 32'h0020006F, 32'hFFFFF0EF, 32'h000012B7, 32'h01010113, 32'h40145413,
           32'h40940433, 32'h00947433, 32'h00040163, 32'hFE041FE3, 32'h00309093, 32'h00412083,
           32'h00112223, 32'h00B00533, 32'h00B50533, 32'h000280E7, 32'h00000013,
           32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    xi = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
           1, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 31; i++) begin
      up = (i == 23) ? 16'hABCD : 16'($urandom());
      drive(i[0], {up, ci[i]}, xo[i], 1'b1, xi[i]);
      #1;
      e   = sb.pop_front();
      got = e.fpu ? {b1.instr_o, b1.is_compressed_o, b1.illegal_instr_o}
                  : {b0.instr_o, b0.is_compressed_o, b0.illegal_instr_o};
      checks++;
      if (got !== {e.o, e.c, e.ill}) begin
        errors++;
        $display("FAIL expand_%0d in=%h got o=%h c=%b ill=%b exp o=%h c=%b ill=%b",
                 i, e.in, got[33:2], got[1], got[0], e.o, e.c, e.ill);
      end
    end
  endtask

  task automatic test_fpu();
    exp_t        e;
    logic [33:0] got;
    logic [15:0] up;
    logic [15:0] ci [5];
    logic [31:0] xo [5];
    ci = '{16'h6000, 16'hE488, 16'h6092, 16'hE206, 16'h2000};
    xo = '{32'h00042407, 32'h00A4A427, 32'h00412087, 32'h00112227, 32'h0};
    for (int i = 0; i < 5; i++) begin
      for (int f = 0; f < 2; f++) begin
        up = 16'($urandom());
        // 16'h2000 (C.FLD) is illegal whether or not the FPU option is present.
        drive(f[0], {up, ci[i]}, xo[i], 1'b1, (f == 0) || (i == 4));
        #1;
        e   = sb.pop_front();
        got = e.fpu ? {b1.instr_o, b1.is_compressed_o, b1.illegal_instr_o}
                    : {b0.instr_o, b0.is_compressed_o, b0.illegal_instr_o};
        checks++;
        if (got !== {e.o, e.c, e.ill}) begin
          errors++;
          $display("FAIL fpu%0d_%0d in=%h got o=%h c=%b ill=%b exp o=%h c=%b ill=%b",
                   f, i, e.in, got[33:2], got[1], got[0], e.o, e.c, e.ill);
        end
      end
    end
  endtask

  initial begin
    rst_ni     = 1'b0;
    b0.instr_i = 32'h0;
    b1.instr_i = 32'h0;
    test_reset();
    test_passthrough();
    test_expand();
    test_fpu();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    checks++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
